// File: rtl/fpu_div_e.sv
// Iterative restoring fdiv.s for the E stage: one quotient bit per cycle, flush-to-zero,
// truncating (round-toward-zero) result; FPUOkE holds the pipeline while the divide runs.
module fpu_div_e #(
  parameter int ITER = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic        FlushE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        FPUOkE,
  output logic [31:0] ResultE
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [24:0]        q_q, q_d;
  logic [24:0]        rem_q, rem_d;
  logic [23:0]        mb_q, mb_d;
  logic signed [9:0]  ediff_q, ediff_d;
  logic               sign_q, sign_d;
  logic               spec_q, spec_d;
  logic [31:0]        specres_q, specres_d;
  logic               qbit;
  logic [24:0]        diff;

  // Returns {is_special, special_result}; operands with a zero exponent count as zero.
  function automatic logic [32:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (&a[30:23]) && (a[22:0] == 23'd0);
    b_inf  = (&b[30:23]) && (b[22:0] == 23'd0);
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      return {1'b1, 32'h7FC00000};
    if (a_inf || (b_zero && !a_zero))
      return {1'b1, s, 31'h7F800000};
    if (a_zero || b_inf)
      return {1'b1, s, 31'd0};
    return {1'b0, 32'd0};
  endfunction

  // Normalize the 25-bit quotient and saturate: overflow clamps to max finite, underflow to zero.
  function automatic logic [31:0] norm_pack(input logic s, input logic signed [9:0] ediff,
                                            input logic [24:0] q);
    logic signed [9:0] e;
    logic [22:0]       f;
    if (q[24]) begin
      e = ediff + 10'sd127;
      f = q[23:1];
    end else begin
      e = ediff + 10'sd126;
      f = q[22:0];
    end
    if (e >= 10'sd255)
      return {s, 31'h7F7FFFFF};
    else if (e <= 10'sd0)
      return {s, 31'd0};
    else
      return {s, e[7:0], f};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    rem_d     = rem_q;
    mb_d      = mb_q;
    ediff_d   = ediff_q;
    sign_d    = sign_q;
    spec_d    = spec_q;
    specres_d = specres_q;
    FPUOkE    = 1'b1;
    qbit      = (rem_q >= {1'b0, mb_q});
    diff      = rem_q - {1'b0, mb_q};
    case (state_q)
      IDLE: begin
        if (StartE && !FlushE) begin
          FPUOkE               = 1'b0;
          state_d              = BUSY;
          cnt_d                = 5'd0;
          q_d                  = 25'd0;
          rem_d                = {2'b01, SrcAE[22:0]};
          mb_d                 = {1'b1, SrcBE[22:0]};
          ediff_d              = $signed({2'b00, SrcAE[30:23]}) - $signed({2'b00, SrcBE[30:23]});
          sign_d               = SrcAE[31] ^ SrcBE[31];
          {spec_d, specres_d}  = classify(SrcAE, SrcBE);
        end
      end
      BUSY: begin
        FPUOkE = 1'b0;
        cnt_d  = cnt_q + 5'd1;
        q_d    = {q_q[23:0], qbit};
        rem_d  = (qbit ? diff : rem_q) << 1;
        if (cnt_q == 5'(ITER - 1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (FlushE)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      q_q     <= 25'd0;
      rem_q   <= 25'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    mb_q      <= mb_d;
    ediff_q   <= ediff_d;
    sign_q    <= sign_d;
    spec_q    <= spec_d;
    specres_q <= specres_d;
  end

  assign ResultE = (state_q == DONE) ? (spec_q ? specres_q : norm_pack(sign_q, ediff_q, q_q))
                                     : 32'd0;

endmodule
